// File: rtl/myram_sp_pkg.sv
// Shared types and constants for the myram_sp single-port RAM controller.
// Build option: MYRAM_SP_OUT_REG_EN adds an output register stage (read latency 2).
package myram_sp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 64;

`ifdef MYRAM_SP_OUT_REG_EN
    localparam int READ_LATENCY = 2;
`else
    localparam int READ_LATENCY = 1;
`endif

endpackage

// File: rtl/myram_sp_core.sv
// Inferred WIDTH x DEPTH single-port array: synchronous write, synchronous read.
// Kept free of control logic so a vendor RAM macro can drop in with the same ports.
module myram_sp_core
    import myram_sp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register have no reset; a reset would stop
    // RAM inference, and the controller's sweep defines the contents instead.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/myram_sp_ctrl.sv
// Single-port RAM controller: zero-fill sequencer, valid/ready request port, fixed-latency reads.
// Build option: MYRAM_SP_OUT_REG_EN registers rsp_* after the array (latency 2 instead of 1).
module myram_sp_ctrl
    import myram_sp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    output logic             init_busy,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_address,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    count;

    logic             accept;
    logic             in_range;

    logic             port_we;
    logic [AW-1:0]    port_address;
    logic [WIDTH-1:0] port_data;
    logic             port_rd;
    logic             port_err;

    logic [WIDTH-1:0] q;
    logic             read_valid;
    logic             read_err;

    assign accept   = req_valid && req_ready;
    assign in_range = {1'b0, req_address} < DEPTH_W;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            count     <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (clear) begin
                        count <= '0;
                    end else if (count == LAST_ADDR) begin
                        state     <= RUN;
                        count     <= '0;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end else begin
                        count <= count + AW'(1);
                    end
                end
                RUN: begin
                    if (clear) begin
                        state     <= INIT;
                        count     <= '0;
                        req_ready <= 1'b0;
                        init_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Every array access (sweep or request) passes through this one stage, so
    // a request accepted alongside clear reaches the array before the first sweep write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            port_we      <= 1'b0;
            port_address <= '0;
            port_data    <= '0;
            port_rd      <= 1'b0;
            port_err     <= 1'b0;
        end else if (state == INIT) begin
            port_we      <= 1'b1;
            port_address <= count;
            port_data    <= '0;
            port_rd      <= 1'b0;
            port_err     <= 1'b0;
        end else begin
            port_we      <= accept && req_we && in_range;
            port_address <= req_address;
            port_data    <= req_data;
            port_rd      <= accept && !req_we;
            port_err     <= !in_range;
        end
    end

    myram_sp_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clock   (clock),
        .we      (port_we),
        .address (port_address),
        .data    (port_data),
        .q       (q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_valid <= 1'b0;
            read_err   <= 1'b0;
        end else begin
            read_valid <= port_rd;
            read_err   <= port_err;
        end
    end

`ifdef MYRAM_SP_OUT_REG_EN
    logic             out_valid;
    logic             out_err;
    logic [WIDTH-1:0] out_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= read_valid;
            out_err   <= read_valid && read_err;
            out_data  <= (read_valid && !read_err) ? q : '0;
        end
    end

    assign rsp_valid = out_valid;
    assign rsp_err   = out_err;
    assign rsp_data  = out_data;
`else
    // Out-of-range and idle cycles are zeroed on the array's read register output.
    assign rsp_valid = read_valid;
    assign rsp_err   = read_valid && read_err;
    assign rsp_data  = (read_valid && !read_err) ? q : '0;
`endif

endmodule

// File: tb/tb_myram_sp_ctrl.sv
// Self-checking bench for myram_sp_ctrl: a DEPTH=64 and a DEPTH=48 instance share stimulus,
// each compared every cycle against a countdown/array model. Honours MYRAM_SP_OUT_REG_EN.
module tb_myram_sp_ctrl;

`ifdef MYRAM_SP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        req_valid;
    logic        req_we;
    logic [5:0]  req_address;
    logic [15:0] req_data;

    logic        obs_busy  [2];
    logic        obs_ready [2];
    logic        obs_valid [2];
    logic        obs_err   [2];
    logic [15:0] obs_data  [2];

    int          depth_of [2] = '{64, 48};
    logic [15:0] mem_m    [2][64];
    int          init_left[2];
    bit          exp_v    [2][4];
    logic [15:0] exp_d    [2][4];
    bit          exp_e    [2][4];

    int    ecount = 0;
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    always #5 clock = ~clock;

    myram_sp_ctrl #(.WIDTH(16), .DEPTH(64)) u_dut64 (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .init_busy   (obs_busy[0]),
        .req_valid   (req_valid),
        .req_ready   (obs_ready[0]),
        .req_we      (req_we),
        .req_address (req_address),
        .req_data    (req_data),
        .rsp_valid   (obs_valid[0]),
        .rsp_data    (obs_data[0]),
        .rsp_err     (obs_err[0])
    );

    myram_sp_ctrl #(.WIDTH(16), .DEPTH(48)) u_dut48 (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .init_busy   (obs_busy[1]),
        .req_valid   (req_valid),
        .req_ready   (obs_ready[1]),
        .req_we      (req_we),
        .req_address (req_address),
        .req_data    (req_data),
        .rsp_valid   (obs_valid[1]),
        .rsp_data    (obs_data[1]),
        .rsp_err     (obs_err[1])
    );

    // Reset or clear: array reads as zero once the sweep is done, busy for DEPTH edges.
    task automatic model_restart(input int d);
        init_left[d] = depth_of[d];
        for (int a = 0; a < 64; a++) mem_m[d][a] = '0;
    endtask

    task automatic model_edge(input int d);
        int s;
        if (!reset_n) begin
            model_restart(d);
            for (int k = 0; k < 4; k++) exp_v[d][k] = 1'b0;
        end else if (init_left[d] == 0) begin
            if (req_valid) begin
                if (req_we) begin
                    if (int'(req_address) < depth_of[d]) mem_m[d][req_address] = req_data;
                end else begin
                    s = (ecount + LAT) % 4;
                    exp_v[d][s] = 1'b1;
                    exp_e[d][s] = !(int'(req_address) < depth_of[d]);
                    exp_d[d][s] = exp_e[d][s] ? 16'h0000 : mem_m[d][req_address];
                end
            end
            if (clear) model_restart(d);
        end else begin
            if (clear) init_left[d] = depth_of[d];
            else       init_left[d] = init_left[d] - 1;
        end
    endtask

    // One clock edge: advance the model, then compare every output of both instances.
    task automatic step();
        @(posedge clock);
        ecount++;
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            int          s;
            logic        w_rdy;
            logic        w_val;
            logic        w_err;
            logic [15:0] w_dat;
            s     = ecount % 4;
            w_rdy = (init_left[d] == 0);
            w_val = exp_v[d][s];
            w_err = w_val ? exp_e[d][s] : 1'b0;
            w_dat = w_val ? exp_d[d][s] : 16'h0000;
            exp_v[d][s] = 1'b0;
            checks += 5;
            if (obs_ready[d] !== w_rdy) begin
                errors++;
                $display("FAIL %s dut%0d edge %0d req_ready got %b want %b", phase, d, ecount, obs_ready[d], w_rdy);
            end
            if (obs_busy[d] !== !w_rdy) begin
                errors++;
                $display("FAIL %s dut%0d edge %0d init_busy got %b want %b", phase, d, ecount, obs_busy[d], !w_rdy);
            end
            if (obs_valid[d] !== w_val) begin
                errors++;
                $display("FAIL %s dut%0d edge %0d rsp_valid got %b want %b", phase, d, ecount, obs_valid[d], w_val);
            end
            if (obs_err[d] !== w_err) begin
                errors++;
                $display("FAIL %s dut%0d edge %0d rsp_err got %b want %b", phase, d, ecount, obs_err[d], w_err);
            end
            if (obs_data[d] !== w_dat) begin
                errors++;
                $display("FAIL %s dut%0d edge %0d rsp_data got %h want %h", phase, d, ecount, obs_data[d], w_dat);
            end
        end
    endtask

    task automatic drive(input logic v, input logic we, input int a, input logic [15:0] dat);
        req_valid   = v;
        req_we      = we;
        req_address = 6'(a);
        req_data    = dat;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 16'h0000);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        int rise[2];
        phase = "reset";
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_ready[d] !== 1'b0 || obs_busy[d] !== 1'b1 || obs_valid[d] !== 1'b0 ||
                obs_err[d] !== 1'b0 || obs_data[d] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_values dut%0d got rdy=%b busy=%b val=%b err=%b data=%h want 0 1 0 0 0000",
                         d, obs_ready[d], obs_busy[d], obs_valid[d], obs_err[d], obs_data[d]);
            end
        end
        rise = '{0, 0};
        drive(1'b1, 1'b0, 0, 16'h0000);
        reset_n = 1'b1;
        for (int n = 1; n <= 200 && (rise[0] == 0 || rise[1] == 0); n++) begin
            step();
            for (int d = 0; d < 2; d++) if (obs_ready[d] === 1'b1 && rise[d] == 0) rise[d] = n;
        end
        idle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rise[d] != depth_of[d]) begin
                errors++;
                $display("FAIL init_duration dut%0d got %0d edges want %0d", d, rise[d], depth_of[d]);
            end
        end
        repeat (LAT + 1) step();
    endtask

    task automatic test_init_zero();
        int good0 = 0;
        int err1  = 0;
        phase = "init_zero";
        for (int a = 0; a < 64 + LAT + 1; a++) begin
            if (a < 64) drive(1'b1, 1'b0, a, 16'h0000);
            else        idle();
            step();
            if (obs_valid[0] === 1'b1 && obs_data[0] === 16'h0000 && obs_err[0] === 1'b0) good0++;
            if (obs_valid[1] === 1'b1 && obs_err[1] === 1'b1) err1++;
        end
        checks += 2;
        if (good0 != 64) begin
            errors++;
            $display("FAIL zero_reads dut0 got %0d zero responses want 64", good0);
        end
        if (err1 != 16) begin
            errors++;
            $display("FAIL oor_reads dut1 got %0d err responses want 16", err1);
        end
    endtask

    task automatic test_write_read();
        int n;
        phase = "write_read";
        drive(1'b1, 1'b1, 5, 16'hA5A5);  step();
        drive(1'b1, 1'b1, 63, 16'h1234); step();
        drive(1'b1, 1'b0, 5, 16'h0000);  step();
        n = ecount;
        drive(1'b1, 1'b0, 63, 16'h0000); step();
        idle();
        while (ecount < n + LAT) step();
        checks++;
        if (obs_valid[0] !== 1'b1 || obs_data[0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL first_rsp at N+%0d got v=%b d=%h want v=1 d=a5a5", LAT, obs_valid[0], obs_data[0]);
        end
        step();
        checks += 2;
        if (obs_valid[0] !== 1'b1 || obs_data[0] !== 16'h1234) begin
            errors++;
            $display("FAIL second_rsp at N+%0d got v=%b d=%h want v=1 d=1234", LAT + 1, obs_valid[0], obs_data[0]);
        end
        if (obs_valid[1] !== 1'b1 || obs_err[1] !== 1'b1 || obs_data[1] !== 16'h0000) begin
            errors++;
            $display("FAIL dut1_addr63 got v=%b e=%b d=%h want v=1 e=1 d=0000", obs_valid[1], obs_err[1], obs_data[1]);
        end
        repeat (LAT + 1) step();
    endtask

    task automatic test_out_of_range();
        int n;
        int k = 0;
        int bad = 0;
        logic [15:0] got[48];
        phase = "out_of_range";
        drive(1'b1, 1'b0, 50, 16'h0000); step();
        n = ecount;
        idle();
        while (ecount < n + LAT) step();
        checks++;
        if (obs_valid[1] !== 1'b1 || obs_err[1] !== 1'b1 || obs_data[1] !== 16'h0000) begin
            errors++;
            $display("FAIL read50 dut1 got v=%b e=%b d=%h want v=1 e=1 d=0000", obs_valid[1], obs_err[1], obs_data[1]);
        end
        drive(1'b1, 1'b1, 50, 16'hFFFF); step();
        for (int a = 48; a <= 50; a++) begin
            drive(1'b1, 1'b0, a, 16'h0000); step();
        end
        idle();
        repeat (LAT + 1) step();
        for (int a = 0; a < 48 + LAT + 1; a++) begin
            if (a < 48) drive(1'b1, 1'b0, a, 16'h0000);
            else        idle();
            step();
            if (obs_valid[1] === 1'b1 && k < 48) begin
                got[k] = obs_data[1];
                k++;
            end
        end
        for (int i = 0; i < k; i++) if (got[i] !== ((i == 5) ? 16'hA5A5 : 16'h0000)) bad++;
        checks++;
        if (k != 48 || bad != 0) begin
            errors++;
            $display("FAIL inrange_intact dut1 got %0d responses %0d wrong want 48 responses 0 wrong", k, bad);
        end
    endtask

    task automatic test_clear();
        int c;
        int rise[2];
        phase = "clear";
        drive(1'b1, 1'b0, 5, 16'h0000);
        clear = 1'b1;
        step();
        c = ecount;
        idle();
        checks++;
        if (obs_busy[0] !== 1'b1 || obs_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL clear_entry got busy=%b ready=%b want busy=1 ready=0", obs_busy[0], obs_ready[0]);
        end
        while (ecount < c + LAT) step();
        checks++;
        if (obs_valid[0] !== 1'b1 || obs_data[0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL preclear_read got v=%b d=%h want v=1 d=a5a5", obs_valid[0], obs_data[0]);
        end
        rise = '{0, 0};
        for (int n = 0; n < 200 && (rise[0] == 0 || rise[1] == 0); n++) begin
            for (int d = 0; d < 2; d++) if (obs_ready[d] === 1'b1 && rise[d] == 0) rise[d] = ecount - c;
            if (rise[0] == 0 || rise[1] == 0) step();
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rise[d] != depth_of[d]) begin
                errors++;
                $display("FAIL clear_duration dut%0d got %0d edges want %0d", d, rise[d], depth_of[d]);
            end
        end
        drive(1'b1, 1'b0, 5, 16'h0000); step();
        c = ecount;
        idle();
        while (ecount < c + LAT) step();
        checks++;
        if (obs_valid[0] !== 1'b1 || obs_data[0] !== 16'h0000) begin
            errors++;
            $display("FAIL postclear_read got v=%b d=%h want v=1 d=0000", obs_valid[0], obs_data[0]);
        end
        repeat (LAT + 1) step();
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        int rise = 0;
        phase = "reset_inflight";
        drive(1'b1, 1'b1, 7, 16'h7777); step();
        for (int i = 0; i < LAT; i++) begin
            drive(1'b1, 1'b0, 7, 16'h0000); step();
        end
        idle();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_ready[d] !== 1'b0 || obs_busy[d] !== 1'b1 || obs_valid[d] !== 1'b0 || obs_data[d] !== 16'h0000) begin
                errors++;
                $display("FAIL async_reset dut%0d got rdy=%b busy=%b val=%b data=%h want 0 1 0 0000",
                         d, obs_ready[d], obs_busy[d], obs_valid[d], obs_data[d]);
            end
        end
        step();
        reset_n = 1'b1;
        for (int n = 1; n <= 200 && rise == 0; n++) begin
            step();
            if (obs_valid[0] === 1'b1 || obs_valid[1] === 1'b1) pulses++;
            if (obs_ready[0] === 1'b1) rise = n;
        end
        checks += 2;
        if (pulses != 0) begin
            errors++;
            $display("FAIL discarded_reads got %0d rsp_valid pulses want 0", pulses);
        end
        if (rise != 64) begin
            errors++;
            $display("FAIL resweep_duration got %0d edges want 64", rise);
        end
    endtask

    task automatic test_random();
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 2) == 1, int'($urandom % 64), 16'($urandom));
            clear = (($urandom % 90) == 0);
            step();
        end
        idle();
        repeat (LAT + 2) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at edge %0d", ecount);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        for (int d = 0; d < 2; d++) begin
            model_restart(d);
            for (int k = 0; k < 4; k++) exp_v[d][k] = 1'b0;
        end
        repeat (3) step();
        test_reset();
        test_init_zero();
        test_write_read();
        test_out_of_range();
        test_clear();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
